sequence_generator: RTL and testbench
=====================================

Name: sequence_generator

Overview:
- Serial bit-pattern transmitter; the generating end of the team's serial pattern-detector links.
- Loads a PAT_W-bit pattern and a length on a start handshake, then shifts the pattern out MSB-first, one bit per clock.
- Repeats the pattern a programmed number of times, or indefinitely, with an optional idle gap between repetitions.
- Used as stimulus source and link driver for the serial detectors (e.g. the 1011 detector).

Parameters:
- PAT_W, 8, maximum pattern length in bits.
- LEN_W, $clog2(PAT_W+1), width of len port.
- GAP_CYC, 0, idle cycles inserted between repetitions (0 = back-to-back).

Ports:
- clk  input  1  rising-edge clock; the single clock domain.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  request; sampled only in IDLE.
- pattern  input  PAT_W  bits to send; the active bits are pattern[len-1:0], sent bit len-1 first.
- len  input  LEN_W  number of bits per repetition; valid range 1..PAT_W.
- reps  input  8  repetition count; 0 = continuous until stop.
- stop  input  1  graceful termination request.
- out  output  1  serial data bit.
- out_valid  output  1  out carries a pattern bit this cycle.
- busy  output  1  block is not in IDLE.
- done  output  1  one-cycle pulse after the last bit of the final repetition.

Behaviour:
- All outputs are registered. While rst=0, regardless of clock: state=IDLE; out=0, out_valid=0, busy=0, done=0; pattern/len/reps shadows, index, rep counter, gap counter and stop_req all clear. Reset mid-transfer aborts it with no done.
- States: IDLE, SEND, GAP.
- IDLE:
  - start=1 with len!=0 captures pattern, len and reps into shadow registers, sets idx=len-1, rep_cnt=0, clears stop_req, then moves to SEND.
  - len>PAT_W is clamped to PAT_W. start with len=0 is ignored: no busy, no done.
- Latency: the first bit appears (out_valid=1) in the cycle after start is sampled. busy rises in that same cycle.
- SEND:
  - Each cycle: out=pat_q[idx], out_valid=1, idx decrements.
  - When idx==0, the repetition ends. It is the final repetition if stop_req=1, or if reps_q!=0 and rep_cnt==reps_q-1.
  - Final repetition: next state is IDLE, and done=1, busy=0, out_valid=0 in that next cycle.
  - Otherwise rep_cnt increments (saturating at 255 when reps_q=0), idx reloads to len_q-1, and the next state is GAP if GAP_CYC>0, else SEND (no bubble).
- GAP: out=0, out_valid=0 for exactly GAP_CYC cycles, then SEND. If stop_req is set during GAP, the next cycle is IDLE with done=1.
- stop:
  - Sampled in SEND or GAP; sets sticky stop_req. The current repetition always completes.
  - stop in the same cycle as the last bit of a repetition makes that repetition final.
  - Ignored in IDLE.
- start while busy is ignored. Changes to pattern, len or reps while busy have no effect.
- The done cycle is IDLE: start asserted in the done cycle is accepted, and the first bit follows in the next cycle.
- out holds 0 whenever out_valid=0.

Test Plan:
- Reset mid-SEND (rst low for 1 cycle, asynchronous) -> out, out_valid, busy, done all 0 immediately; no done pulse; block idles until the next start.
- pattern=8'h0B, len=4, reps=2, GAP_CYC=0, start at cycle 0 -> out 1,0,1,1,1,0,1,1 with out_valid=1 on cycles 1–8; done=1 and busy=0 on cycle 9.
- Same stimulus with GAP_CYC=2 -> bits on cycles 1–4 and 7–10, out_valid=0 on cycles 5–6, done on cycle 11.
- reps=0, len=3, pattern=3'b101, stop pulsed mid-way through repetition 3 -> repetition 3 finishes fully (bits 1,0,1), done the following cycle, no partial repetition.
- start with len=0 -> busy stays 0, no output, no done. start pulsed while busy with a different pattern -> output unchanged.
- Back-to-back: start held high through the done cycle, with a new pattern -> new pattern's first bit in the cycle after done, no extra idle cycle. Looping out/out_valid into the 1011 detector with pattern 1011, reps=3 -> 3 detections.

Source files
------------

// File: rtl/sequence_generator.sv
// rtl/sequence_generator.sv - serial MSB-first pattern transmitter with repeat count, idle gap and graceful stop
module sequence_generator #(
    parameter int PAT_W   = 8,
    parameter int LEN_W   = $clog2(PAT_W + 1),
    parameter int GAP_CYC = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       reps,
    input  logic             stop,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);
    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int GAP_W = $clog2(GAP_CYC + 2);
    localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t           state;
    logic [PAT_W-1:0] pat_q;
    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] idx;
    logic [7:0]       reps_q;
    logic [7:0]       rep_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             stop_req;

    logic [LEN_W-1:0] len_c;
    logic [IDX_W-1:0] len_m1;
    logic [IDX_W-1:0] idx_dn;
    logic             stop_now;
    logic             last_rep;

    // idx always names the bit currently on out, so the next bit is prepared one edge ahead
    always_comb begin
        len_c    = (len > PAT_W_L) ? PAT_W_L : len;
        len_m1   = IDX_W'(len_c - LEN_W'(1));
        idx_dn   = idx - IDX_W'(1);
        stop_now = stop_req | stop;
        last_rep = stop_now || ((reps_q != 8'd0) && (rep_cnt == reps_q - 8'd1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            pat_q     <= '0;
            last_q    <= '0;
            idx       <= '0;
            reps_q    <= '0;
            rep_cnt   <= '0;
            gap_cnt   <= '0;
            stop_req  <= 1'b0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    out       <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    if (start && (len != '0)) begin
                        pat_q     <= pattern;
                        last_q    <= len_m1;
                        idx       <= len_m1;
                        reps_q    <= reps;
                        rep_cnt   <= 8'd0;
                        gap_cnt   <= '0;
                        stop_req  <= 1'b0;
                        out       <= pattern[len_m1];
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    stop_req <= stop_now;
                    if (idx != '0) begin
                        idx <= idx_dn;
                        out <= pat_q[idx_dn];
                    end else if (last_rep) begin
                        state     <= IDLE;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        out       <= 1'b0;
                        out_valid <= 1'b0;
                    end else begin
                        if (rep_cnt != 8'hFF) begin
                            rep_cnt <= rep_cnt + 8'd1;
                        end
                        idx <= last_q;
                        if (GAP_CYC > 0) begin
                            state     <= GAP;
                            gap_cnt   <= GAP_W'(GAP_CYC - 1);
                            out       <= 1'b0;
                            out_valid <= 1'b0;
                        end else begin
                            out <= pat_q[last_q];
                        end
                    end
                end
                GAP: begin
                    stop_req <= stop_now;
                    if (stop_now) begin
                        state <= IDLE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (gap_cnt == '0) begin
                        state     <= SEND;
                        out       <= pat_q[last_q];
                        out_valid <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sequence_generator.sv
// tb/tb_sequence_generator.sv - vector table, directed corner cases and randomized model check for sequence_generator
module tb_sequence_generator;
    localparam int MAXC = 100;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [7:0] reps;
    logic       stop;
    logic       so0, sv0, sb0, sd0;
    logic       so2, sv2, sb2, sd2;

    int n_cmp;
    int n_bad;

    sequence_generator #(.PAT_W(8), .GAP_CYC(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len), .reps(reps),
        .stop(stop), .out(so0), .out_valid(sv0), .busy(sb0), .done(sd0)
    );

    sequence_generator #(.PAT_W(8), .GAP_CYC(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len), .reps(reps),
        .stop(stop), .out(so2), .out_valid(sv2), .busy(sb2), .done(sd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  pat;
        logic [3:0]  ln;
        logic [7:0]  rp;
        int          sc;
        int          done0;
        int          done2;
        int          n0;
        int          n2;
        logic [15:0] bits0;
    } vec_t;

    vec_t vt [7];

    // {out, out_valid, busy, done} per cycle after start, index 0 = gap 0, index 1 = gap 2
    logic [3:0] expv [2][MAXC];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Timeline built repetition by repetition; a stop seen in a repetition ends the transfer after it
    task automatic build(input int g, input logic [7:0] p, input int ln, input int rp, input int sc);
        int gap, c, rep, lc;
        bit stopped, fin;
        gap = (g == 0) ? 0 : 2;
        for (int i = 0; i < MAXC; i++) expv[g][i] = 4'b0000;
        lc = (ln > 8) ? 8 : ln;
        if (lc == 0) return;
        c = 1; rep = 0; stopped = 0; fin = 0;
        while (!fin && c < MAXC - 1) begin
            for (int b = lc - 1; b >= 0; b--) begin
                if (c < MAXC) expv[g][c] = {p[b], 1'b1, 1'b1, 1'b0};
                if (c == sc) stopped = 1;
                c++;
            end
            rep++;
            if (stopped || (rp != 0 && rep == rp)) begin
                if (c < MAXC) expv[g][c] = 4'b0001;
                fin = 1;
            end else begin
                for (int k = 0; k < gap && !fin; k++) begin
                    if (c < MAXC) expv[g][c] = 4'b0010;
                    c++;
                    if (c - 1 == sc) begin
                        if (c < MAXC) expv[g][c] = 4'b0001;
                        fin = 1;
                    end
                end
            end
        end
    endtask

    int          fd0, fd2, sd0b, sd2b, n0, n2, det0, det2, ndn0, ndn2;
    logic [15:0] acc0, acc2;
    logic [3:0]  sh0, sh2;
    logic        bs0, bs2, v6_0, v6_2;
    logic [7:0]  tp;
    int          tl, tr, tsc;

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b0; start = 1'b0; pattern = 8'h00; len = 4'd0; reps = 8'd0; stop = 1'b0;
        vt[0] = '{8'h0B, 4'd4,  8'd2, -1,  9, 11, 8, 8, 16'h00BB};
        vt[1] = '{8'hFF, 4'd0,  8'd1, -1,  0,  0, 0, 0, 16'h0000};
        vt[2] = '{8'hA5, 4'd8,  8'd1, -1,  9,  9, 8, 8, 16'h00A5};
        vt[3] = '{8'h05, 4'd3,  8'd0,  8, 10,  9, 9, 6, 16'h016D};
        vt[4] = '{8'hC3, 4'd12, 8'd1, -1,  9,  9, 8, 8, 16'h00C3};
        vt[5] = '{8'h01, 4'd1,  8'd3, -1,  4,  8, 3, 3, 16'h0007};
        vt[6] = '{8'h0B, 4'd4,  8'd0,  5,  9,  6, 8, 4, 16'h00BB};

        #3;
        chk("reset state dut0", {12'd0, so0, sv0, sb0, sd0}, 16'h0000);
        chk("reset state dut2", {12'd0, so2, sv2, sb2, sd2}, 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Vector table
        for (int i = 0; i < 7; i++) begin
            fd0 = 0; fd2 = 0; n0 = 0; n2 = 0; acc0 = '0; bs0 = 0; bs2 = 0;
            for (int c = 0; c < 30; c++) begin
                @(negedge clk);
                if (c >= 1) begin
                    if (sd0 && fd0 == 0) fd0 = c;
                    if (sd2 && fd2 == 0) fd2 = c;
                    if (sv0) begin n0++; acc0 = {acc0[14:0], so0}; end
                    if (sv2) n2++;
                    if (sb0) bs0 = 1'b1;
                    if (sb2) bs2 = 1'b1;
                end
                start   = (c == 0);
                pattern = (c == 0) ? vt[i].pat : 8'($urandom);
                len     = (c == 0) ? vt[i].ln : 4'($urandom);
                reps    = (c == 0) ? vt[i].rp : 8'($urandom);
                stop    = (c == vt[i].sc);
            end
            chk($sformatf("vec%0d done cycle gap0", i), 16'(fd0), 16'(vt[i].done0));
            chk($sformatf("vec%0d done cycle gap2", i), 16'(fd2), 16'(vt[i].done2));
            chk($sformatf("vec%0d bit count gap0", i), 16'(n0), 16'(vt[i].n0));
            chk($sformatf("vec%0d bit count gap2", i), 16'(n2), 16'(vt[i].n2));
            chk($sformatf("vec%0d stream gap0", i), acc0, vt[i].bits0);
            chk($sformatf("vec%0d busy seen", i), {14'd0, bs0, bs2}, (vt[i].ln != 0) ? 16'h0003 : 16'h0000);
        end

        // Asynchronous reset in the middle of a continuous transfer
        @(negedge clk); start = 1'b1; pattern = 8'hFF; len = 4'd8; reps = 8'd0; stop = 1'b0;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre-reset sending", {14'd0, sv0, sv2}, 16'h0003);
        #2 rst = 1'b0;
        #1;
        chk("async reset dut0", {12'd0, so0, sv0, sb0, sd0}, 16'h0000);
        chk("async reset dut2", {12'd0, so2, sv2, sb2, sd2}, 16'h0000);
        @(negedge clk); rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("post-reset idle c%0d", c), {8'd0, so0, sv0, sb0, sd0, so2, sv2, sb2, sd2}, 16'h0000);
        end

        // start held through the done cycle, with a different pattern offered while busy
        fd0 = 0; fd2 = 0; sd0b = 0; sd2b = 0; n0 = 0; n2 = 0; acc0 = '0; acc2 = '0; v6_0 = 0; v6_2 = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                if (sd0) begin if (fd0 == 0) fd0 = c; else sd0b = c; end
                if (sd2) begin if (fd2 == 0) fd2 = c; else sd2b = c; end
                if (sv0) begin n0++; acc0 = {acc0[14:0], so0}; end
                if (sv2) begin n2++; acc2 = {acc2[14:0], so2}; end
                if (c == 6) begin v6_0 = sv0 & so0; v6_2 = sv2 & so2; end
            end
            start   = (c <= 5);
            pattern = (c == 0) ? 8'h0B : 8'hF0;
            len     = (c == 0) ? 4'd4 : 4'd8;
            reps    = 8'd1;
            stop    = 1'b0;
        end
        chk("b2b first done gap0", 16'(fd0), 16'd5);
        chk("b2b second done gap0", 16'(sd0b), 16'd14);
        chk("b2b second done gap2", 16'(sd2b), 16'd14);
        chk("b2b first bit after done", {14'd0, v6_0, v6_2}, 16'h0003);
        chk("b2b stream gap0", acc0, 16'h0BF0);
        chk("b2b stream gap2", acc2, 16'h0BF0);
        chk("b2b bit count", 16'(n0 + n2), 16'd24);

        // Valid bits fed into a 1011 detector
        sh0 = '0; sh2 = '0; det0 = 0; det2 = 0; ndn0 = 0; ndn2 = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                if (sv0) begin sh0 = {sh0[2:0], so0}; if (sh0 == 4'b1011) det0++; end
                if (sv2) begin sh2 = {sh2[2:0], so2}; if (sh2 == 4'b1011) det2++; end
                if (sd0) ndn0++;
                if (sd2) ndn2++;
            end
            start = (c == 0); pattern = 8'h0B; len = 4'd4; reps = 8'd3; stop = 1'b0;
        end
        chk("detector hits gap0", 16'(det0), 16'd3);
        chk("detector hits gap2", 16'(det2), 16'd3);
        chk("detector done pulses", 16'(ndn0 + ndn2), 16'd2);

        // Randomized transfers against the timeline model
        for (int t = 0; t < 30; t++) begin
            tp  = 8'($urandom);
            tl  = $urandom_range(0, 12);
            tr  = $urandom_range(0, 4);
            if (tr == 0 || $urandom_range(0, 1) == 1) tsc = $urandom_range(1, 40);
            else tsc = -1;
            build(0, tp, tl, tr, tsc);
            build(1, tp, tl, tr, tsc);
            for (int c = 0; c < MAXC; c++) begin
                @(negedge clk);
                if (c >= 1) begin
                    chk($sformatf("rand t%0d c%0d gap0", t, c), {12'd0, so0, sv0, sb0, sd0}, {12'd0, expv[0][c]});
                    chk($sformatf("rand t%0d c%0d gap2", t, c), {12'd0, so2, sv2, sb2, sd2}, {12'd0, expv[1][c]});
                end
                if (c == 0) begin
                    start = 1'b1; pattern = tp; len = 4'(tl); reps = 8'(tr);
                    stop  = ($urandom_range(0, 1) == 1);
                end else begin
                    start   = expv[0][c][1] && expv[1][c][1] && ($urandom_range(0, 1) == 1);
                    pattern = 8'($urandom);
                    len     = 4'($urandom);
                    reps    = 8'($urandom);
                    stop    = (c == tsc) || (!expv[0][c][1] && !expv[1][c][1] && ($urandom_range(0, 3) == 0));
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
